seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
- Parametrised multi-digit seven-segment scan driver; next generation of the fixed 4-digit BCD7 display output used on the pipeline CPU board.
- Sits between core debug/register outputs and the board's anode/segment pins.
- Adds configurable digit count, scan rate and pin polarity, per-digit decimal points, whole-display blanking, and a tear-free load handshake.

Parameters:
- DIGITS, 4, number of digits scanned; legal range 1..8.
- SCAN_DIV, 50000, clk cycles each digit is held; must be >= 2.
- AN_ACTIVE_LOW, 1, 1 = anode enables driven low when active.
- SEG_ACTIVE_LOW, 1, 1 = segments and DP driven low when lit.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- value_in  input  4*DIGITS  hex nibbles; nibble k drives digit k, digit 0 = rightmost.
- dp_in  input  DIGITS  decimal point per digit, 1 = lit; sampled with value_in.
- load  input  1  single-cycle strobe; captures value_in and dp_in.
- blank  input  1  level; 1 forces all anodes inactive; scanning continues.
- pending  output  1  1 = captured value waiting for frame boundary.
- frame_tick  output  1  one-cycle pulse when digit index wraps DIGITS-1 -> 0.
- BCD7  output  DIGITS+8  {anodes[DIGITS-1:0], dp, seg[6:0]}; seg order gfedcba.

Behaviour:
- Prescaler: counts 0..SCAN_DIV-1, width $clog2(SCAN_DIV), wraps to 0. Terminal count = prescaler at SCAN_DIV-1.
- Digit index: advances on terminal count, modulo DIGITS. Each digit is held SCAN_DIV cycles; one full frame = DIGITS*SCAN_DIV cycles.
- frame_tick: high for exactly the one cycle in which the index goes DIGITS-1 -> 0.
- Value registers:
  - shown: drives the display.
  - pend: capture buffer.
- Load handshake:
  - load=1 writes pend and sets pending=1.
  - At a wrap with pending=1: shown <= pend, pending <= 0. The display therefore never changes mid-frame.
- Boundary cases:
  - load while pending=1: pend is overwritten (last load wins); pending stays 1.
  - load in the same cycle as a wrap with pending=1: old pend is committed to shown; new value goes to pend; pending stays 1.
  - load in the same cycle as a wrap with pending=0: captured only; committed at the next wrap.
  - DIGITS=1: every terminal count is a wrap; frame_tick fires every SCAN_DIV cycles.
- Output register: BCD7 is registered, with one cycle of latency after the index changes. It shows:
  - one-hot anode for the current index;
  - decoded nibble of shown;
  - that digit's dp bit.
- Polarity: inversion is applied after the register according to the polarity parameters.
- Decode (active-high, gfedcba), digits 0-F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- blank=1: all anodes inactive from the next cycle; prescaler, index and load handshake continue unaffected.
- Reset asserted (any time, including mid-frame or with pending=1), all of the following clear immediately:
  - prescaler, index, shown, pend, pending and frame_tick go to 0;
  - BCD7 goes to all anodes inactive, all segments off and dp off at the configured polarity. With defaults, BCD7 = all ones.
- Reset release: the first terminal count occurs SCAN_DIV cycles later. Until a load commits, shown=0, so lit digits display "0".

Optional Feature:
- Macro: SEG_SCAN_LZB_EN.
- Defined: leading-zero blanking. Digits whose nibble is 0 and all of whose more-significant nibbles are 0 have their anode held inactive. Digit 0 is never blanked, so value 0 displays a single "0". A digit's dp=1 keeps that digit and all less-significant digits unblanked.
- Undefined: all digits are always driven; the logic is absent.

Test Plan:
- Reset and scan, with DIGITS=4, SCAN_DIV=4, defaults:
  - Hold reset low -> BCD7=12'hFFF.
  - Release, then load 16'h1234 -> committed at first wrap.
  - Anodes then cycle 1110, 1101, 1011, 0111 (digit 0 first) with segments ~06 (0xF9 incl dp off, "4" on digit 0 is ~66). Each anode pattern is held 4 cycles; frame_tick every 16 cycles.
- Tear-free load: load 16'hABCD at mid-frame -> pending=1, displayed digits unchanged until the wrap cycle. After the wrap, pending=0 and digit 0 shows ~5E ("D").
- Double load: load 16'h1111 then 16'h2222 within one frame -> only 2222 is ever displayed.
- Load at wrap: load 16'h5555 in the wrap cycle while pending=1 -> old pend is shown; 5555 is shown one frame later.
- Blank and reset mid-frame:
  - blank=1 -> anodes 4'hF next cycle, and frame_tick keeps its period.
  - reset low at index 2 -> BCD7=12'hFFF immediately and pending=0.
- SEG_SCAN_LZB_EN defined:
  - value 16'h0070 -> digits 3 and 2 anodes inactive; digit 0 shows "0".
  - value 0 -> only digit 0 lit.
  - dp_in=4'b0100 with value 0 -> digits 2..0 lit.

Source files
------------

// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: load/blank inputs and scan outputs of the seven-segment scan driver.
interface seg_scan_display_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic                blank;
  logic                pending;
  logic                frame_tick;
  logic [DIGITS+7:0]   bcd7;
  modport master (output value, dp, load, blank, input pending, frame_tick, bcd7);
  modport slave (input value, dp, load, blank, output pending, frame_tick, bcd7);
endinterface

// File: rtl/seg_scan_display.sv
// seg_scan_display: multi-digit seven-segment scan driver with frame-aligned value commit.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
module seg_scan_display #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_display_if.slave  bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  logic [PW-1:0]          presc_q, presc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DIGITS-1:0][3:0] shown_q, shown_d, pend_q, pend_d;
  logic [DIGITS-1:0]      shown_dp_q, shown_dp_d, pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]      an_q, an_d, lzb;
  logic [6:0]             seg_q, seg_d;
  logic                   dp_q, dp_d, pending_q, pending_d, tc, wrap;
`ifdef SEG_SCAN_LZB_EN
  logic lead;
  // A digit is blanked while every nibble and dp from it upwards is zero; digit 0 always lit.
  always_comb begin
    lzb  = '0;
    lead = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      lead   = lead && shown_q[k] == 4'h0 && !shown_dp_q[k];
      lzb[k] = lead;
    end
  end
`else
  assign lzb = '0;
`endif
  always_comb begin
    tc         = presc_q == PW'(SCAN_DIV - 1);
    wrap       = tc && idx_q == IW'(DIGITS - 1);
    presc_d    = tc ? '0 : presc_q + 1'b1;
    idx_d      = wrap ? '0 : idx_q + IW'(tc);
    pending_d  = bus.load || (pending_q && !wrap);
    pend_d     = bus.load ? bus.value : pend_q;
    pend_dp_d  = bus.load ? bus.dp : pend_dp_q;
    shown_d    = wrap && pending_q ? pend_q : shown_q;
    shown_dp_d = wrap && pending_q ? pend_dp_q : shown_dp_q;
    an_d       = bus.blank || lzb[idx_q] ? '0 : DIGITS'(1) << idx_q;
    seg_d      = SEG_LUT[shown_q[idx_q]];
    dp_d       = shown_dp_q[idx_q];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      shown_q    <= '0;
      shown_dp_q <= '0;
      pend_q     <= '0;
      pend_dp_q  <= '0;
      pending_q  <= 1'b0;
      an_q       <= '0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      shown_q    <= shown_d;
      shown_dp_q <= shown_dp_d;
      pend_q     <= pend_d;
      pend_dp_q  <= pend_dp_d;
      pending_q  <= pending_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  assign bus.pending    = pending_q;
  assign bus.frame_tick = wrap;
  assign bus.bcd7       = {AN_ACTIVE_LOW ? ~an_q : an_q,
                           SEG_ACTIVE_LOW ? ~{dp_q, seg_q} : {dp_q, seg_q}};
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: scoreboard bench for seg_scan_display with DIGITS=4, SCAN_DIV=4.
// Honours SEG_SCAN_LZB_EN in its expected-value model.
module tb_seg_scan_display;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;
  localparam logic [6:0] LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  typedef struct packed {
    logic [11:0] bcd;
    logic        pend;
  } exp_t;
  logic clk, rst_n;
  int   n_vec, n_bad;
  exp_t sb [$];
  int          m_cnt;
  logic [15:0] m_shown, m_pend;
  logic [3:0]  m_shown_dp, m_pend_dp;
  logic        m_pending;
  seg_scan_display_if #(.DIGITS(DIGITS)) bus ();
  seg_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [11:0] exp_out(input int dig, input logic [15:0] v, input logic [3:0] d,
                                          input logic blk);
    logic off;
    off = blk;
`ifdef SEG_SCAN_LZB_EN
    if (dig > 0 && (v >> (4 * dig)) == 16'h0 && (d >> dig) == 4'h0) off = 1'b1;
`endif
    return {off ? 4'hF : ~(4'b0001 << dig), ~d[dig], ~LUT[v[4*dig+:4]]};
  endfunction
  task automatic model_reset();
    m_cnt = 0;
    m_shown = '0;
    m_pend = '0;
    m_shown_dp = '0;
    m_pend_dp = '0;
    m_pending = 1'b0;
  endtask
  // Called just after a rising edge with this cycle's inputs already driven.
  task automatic step();
    logic wrap;
    exp_t e;
    wrap = m_cnt == FRAME - 1;
    chk("frame_tick", 32'(bus.frame_tick), 32'(wrap));
    e.bcd = exp_out(m_cnt / SCAN_DIV, m_shown, m_shown_dp, bus.blank);
    if (wrap && m_pending) begin
      m_shown = m_pend;
      m_shown_dp = m_pend_dp;
    end
    if (bus.load) begin
      m_pend = bus.value;
      m_pend_dp = bus.dp;
    end
    m_pending = bus.load || (m_pending && !wrap);
    e.pend = m_pending;
    m_cnt = (m_cnt + 1) % FRAME;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask
  task automatic load_step(input logic [15:0] v, input logic [3:0] d);
    bus.load = 1'b1;
    bus.value = v;
    bus.dp = d;
    step();
    bus.load = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic run_to(input int c);
    while (m_cnt != c) step();
  endtask
  always @(negedge clk)
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("bcd7", 32'(bus.bcd7), 32'(e.bcd));
      chk("pending", 32'(bus.pending), 32'(e.pend));
    end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end
  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.load = 1'b0;
    bus.blank = 1'b0;
    bus.value = '0;
    bus.dp = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bcd7", 32'(bus.bcd7), 32'h0FFF);
    chk("reset_pending", 32'(bus.pending), 32'h0);
    chk("reset_tick", 32'(bus.frame_tick), 32'h0);
    rst_n = 1'b1;
    load_step(16'h1234, 4'b0000);
    idle(40);
    run_to(6);
    load_step(16'hABCD, 4'b0000);
    idle(30);
    run_to(2);
    load_step(16'h1111, 4'b0000);
    run_to(9);
    load_step(16'h2222, 4'b0000);
    idle(24);
    run_to(3);
    load_step(16'h3333, 4'b0000);
    run_to(15);
    load_step(16'h5555, 4'b0000);
    idle(40);
    run_to(15);
    load_step(16'h0707, 4'b0000);
    idle(36);
    load_step(16'h1234, 4'b0101);
    idle(34);
    bus.blank = 1'b1;
    idle(20);
    bus.blank = 1'b0;
    idle(4);
    load_step(16'h0070, 4'b0000);
    idle(36);
    load_step(16'h0000, 4'b0000);
    idle(36);
    load_step(16'h0000, 4'b0100);
    idle(36);
    run_to(1);
    load_step(16'h9876, 4'b0010);
    run_to(9);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_bcd7", 32'(bus.bcd7), 32'h0FFF);
    chk("midrst_pending", 32'(bus.pending), 32'h0);
    chk("midrst_tick", 32'(bus.frame_tick), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    chk("held_rst_bcd7", 32'(bus.bcd7), 32'h0FFF);
    rst_n = 1'b1;
    idle(20);
    load_step(16'hF0E1, 4'b1000);
    idle(36);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
